// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave controller.
// Byte framing: bits 0..7 are data (MSB first), bit 8 is the ACK slot.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_SKIP
    } i2c_state_e;

    localparam int         BYTE_BITS = 8;
    localparam logic [3:0] ACK_BIT   = 4'd8;
    localparam logic [3:0] LAST_BIT  = 4'(BYTE_BITS - 1);

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers plus edge history.
// Produces SCL edges and START/STOP from the synchronised pins.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   w_scl;
    logic                   w_sda;

    // Preset to 1 so a reset looks like an idle bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_hist;
    assign o_scl_fall = ~w_scl & r_scl_hist;
    assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave: address match, write receive, read transmit.
// Owns bit/ACK counting and the open-drain SDA drive.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_rx
);

    i2c_state_e r_state;
    i2c_state_e w_state_nxt;

    logic                 w_sda;
    logic                 w_rise_raw;
    logic                 w_fall_raw;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_bus_evt;
    logic                 w_rise;
    logic                 w_fall_edge;
    logic                 w_fall;
    logic                 w_last;
    logic                 w_match;
    logic [7:0]           w_shift_nxt;

    logic [3:0]           r_cnt;
    logic                 r_first;
    logic [BYTE_BITS-2:0] r_shift;
    logic [7:0]           r_tx_shift;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_nack;
    logic                 r_sda_oe;
    logic                 r_hit;
    logic                 r_rw;

    logic                 w_sda_oe_nxt;
    logic                 w_rx_load;
    logic                 w_tx_req;
    logic                 w_tx_adv;
    logic                 w_nack;
    logic                 w_busy;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_scl      (scl),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise_raw),
        .o_scl_fall (w_fall_raw),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // Bus conditions win over SCL edges in the same clk.
    // The SCL fall that completes a START is not a bit boundary.
    assign w_bus_evt   = w_start | w_stop;
    assign w_rise      = w_rise_raw & ~w_bus_evt;
    assign w_fall_edge = w_fall_raw & ~w_bus_evt;
    assign w_fall      = w_fall_edge & ~r_first;
    assign w_last      = (r_cnt == LAST_BIT);
    assign w_shift_nxt = {r_shift, w_sda};
    assign w_match     = (w_shift_nxt[7:1] == ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_ADDR: begin
                    if (w_rise && w_last && !w_match)
                        w_state_nxt = ST_SKIP;
                    else if (w_fall && w_last && r_hit)
                        w_state_nxt = ST_ADDR_ACK;
                end
                ST_ADDR_ACK:
                    if (w_fall)
                        w_state_nxt = r_rw ? ST_RD_DATA : ST_WR_DATA;
                ST_WR_DATA:
                    if (w_fall && w_last) w_state_nxt = ST_WR_ACK;
                ST_WR_ACK:
                    if (w_fall) w_state_nxt = ST_WR_DATA;
                ST_RD_DATA:
                    if (w_fall && w_last) w_state_nxt = ST_RD_ACK;
                ST_RD_ACK: begin
                    if (w_rise && w_sda)
                        w_state_nxt = ST_SKIP;
                    else if (w_fall)
                        w_state_nxt = ST_RD_DATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_sda_oe_nxt = r_sda_oe;
        w_rx_load    = 1'b0;
        w_tx_req     = 1'b0;
        w_tx_adv     = 1'b0;
        w_nack       = 1'b0;
        if (w_bus_evt) begin
            w_sda_oe_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_ADDR: begin
                    w_tx_req = w_rise && w_last && w_match
                               && w_shift_nxt[0];
                    if (w_fall && w_last && r_hit)
                        w_sda_oe_nxt = 1'b1;
                end
                ST_ADDR_ACK:
                    if (w_fall)
                        w_sda_oe_nxt = r_rw & ~r_tx_shift[7];
                ST_WR_DATA: begin
                    w_rx_load = w_rise && w_last;
                    if (w_fall && w_last)
                        w_sda_oe_nxt = 1'b1;
                end
                ST_WR_ACK:
                    if (w_fall) w_sda_oe_nxt = 1'b0;
                ST_RD_DATA:
                    if (w_fall) begin
                        w_tx_adv     = !w_last;
                        w_sda_oe_nxt = !w_last && !r_tx_shift[6];
                    end
                ST_RD_ACK: begin
                    w_tx_req = w_rise && !w_sda;
                    w_nack   = w_rise && w_sda;
                    if (w_fall)
                        w_sda_oe_nxt = ~r_tx_shift[7];
                end
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_first    <= 1'b1;
            r_shift    <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_nack     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_hit      <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_valid <= w_rx_load;
            r_nack     <= w_nack;
            if (w_rx_load)
                r_rx_data <= w_shift_nxt;
            if (w_tx_req)
                r_tx_shift <= tx_data;
            else if (w_tx_adv)
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            if (w_start) begin
                r_cnt   <= '0;
                r_first <= 1'b1;
                r_hit   <= 1'b0;
                r_rw    <= 1'b0;
            end else if (!w_stop) begin
                if (w_fall_edge) begin
                    if (r_first)
                        r_first <= 1'b0;
                    else if (r_cnt == ACK_BIT)
                        r_cnt <= '0;
                    else
                        r_cnt <= r_cnt + 4'd1;
                end
                if (w_rise)
                    r_shift <= w_shift_nxt[BYTE_BITS-2:0];
                if (r_state == ST_ADDR && w_rise && w_last) begin
                    r_hit <= w_match;
                    r_rw  <= w_shift_nxt[0];
                end
            end
        end
    end

    assign w_busy = (r_state == ST_ADDR_ACK) || (r_state == ST_WR_DATA)
                 || (r_state == ST_WR_ACK) || (r_state == ST_RD_DATA)
                 || (r_state == ST_RD_ACK);

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = w_tx_req;
    assign busy     = w_busy;
    assign nack_rx  = r_nack;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-banged I2C master, transaction table,
// scoreboard queues for received and transmitted bytes.
module tb_i2c_slave_ctrl;

    typedef struct {
        logic [7:0]      addr;
        int              n;
        logic [1:0][7:0] d;
        logic            exp_ack;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;
    logic       nack_rx;

    int checks = 0;
    int errors = 0;
    int n_rx = 0;
    int n_txreq = 0;
    int n_nack = 0;
    int n_oe = 0;
    logic p_rx = 1'b0;
    logic p_tx = 1'b0;
    logic p_nk = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    assign sda_in = m_sda & ~sda_oe;

    i2c_slave_ctrl #(
        .ADDR        (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .nack_rx  (nack_rx)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (sda_oe) n_oe++;
            if (tx_req) n_txreq++;
            if (nack_rx) n_nack++;
            if (rx_valid) begin
                n_rx++;
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected none",
                             rx_data);
                end else begin
                    chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                end
            end
            if (rx_valid || tx_req || nack_rx)
                chk("pulse_width",
                    {29'd0, rx_valid & p_rx, tx_req & p_tx, nack_rx & p_nk},
                    32'd0);
            p_rx = rx_valid;
            p_tx = tx_req;
            p_nk = nack_rx;
        end
    end

    function automatic vec_t mk(input logic [7:0] a, input int n,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic ack);
        vec_t v;
        v.addr    = a;
        v.n       = n;
        v.d[0]    = d0;
        v.d[1]    = d1;
        v.exp_ack = ack;
        return v;
    endfunction

    task automatic q();
        repeat (4) @(negedge clk);
    endtask

    task automatic start_c();
        m_sda = 1'b1; q();
        scl = 1'b1;   q();
        m_sda = 1'b0; q();
        scl = 1'b0;   q();
    endtask

    task automatic stop_c();
        m_sda = 1'b0; q();
        scl = 1'b1;   q();
        m_sda = 1'b1; q();
        q();
    endtask

    task automatic bit_out(input logic b);
        m_sda = b;  q();
        scl = 1'b1; q();
        q();
        scl = 1'b0; q();
    endtask

    task automatic ack_in(output logic ack);
        m_sda = 1'b1; q();
        scl = 1'b1;   q();
        ack = !sda_in; q();
        scl = 1'b0;   q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        ack_in(ack);
    endtask

    task automatic read_data(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_sda = 1'b1; q();
            scl = 1'b1;   q();
            b = {b[6:0], sda_in}; q();
            scl = 1'b0;   q();
        end
    endtask

    task automatic ack_out(input logic a);
        m_sda = !a; q();
        scl = 1'b1; q();
        q();
        scl = 1'b0; q();
    endtask

    task automatic run_vec(input vec_t v);
        logic       ack;
        logic       rd;
        logic [7:0] b;
        int         rx0;
        int         tq0;
        int         nk0;
        rd  = v.addr[0];
        rx0 = n_rx;
        tq0 = n_txreq;
        nk0 = n_nack;
        n_oe = 0;
        if (rd && v.exp_ack) begin
            tx_data = v.d[0];
            exp_rd.push_back(v.d[0]);
        end
        start_c();
        write_byte(v.addr, ack);
        chk("addr_ack", 32'(ack), 32'(v.exp_ack));
        chk("busy_active", 32'(busy), 32'(v.exp_ack));
        for (int i = 0; i < v.n; i++) begin
            if (!rd) begin
                if (v.exp_ack) exp_rx.push_back(v.d[i]);
                write_byte(v.d[i], ack);
                chk("data_ack", 32'(ack), 32'(v.exp_ack));
            end else if (v.exp_ack) begin
                read_data(b);
                chk("rd_byte", 32'(b), 32'(exp_rd.pop_front()));
                if (i < v.n - 1) begin
                    tx_data = v.d[i+1];
                    exp_rd.push_back(v.d[i+1]);
                end
                ack_out(i < v.n - 1);
            end
        end
        if (rd && v.exp_ack)
            chk("oe_after_nack", 32'(sda_oe), 32'd0);
        stop_c();
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("rx_left", 32'(exp_rx.size()), 32'd0);
        chk("rx_count", 32'(n_rx - rx0),
            (!rd && v.exp_ack) ? 32'(v.n) : 32'd0);
        if (rd) begin
            chk("txreq_count", 32'(n_txreq - tq0),
                v.exp_ack ? 32'(v.n) : 32'd0);
            chk("nack_count", 32'(n_nack - nk0),
                v.exp_ack ? 32'd1 : 32'd0);
        end
        if (!v.exp_ack)
            chk("oe_never", 32'(n_oe), 32'd0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [7:0] a;
        int         rx0;
        int         tq0;

        vecs[0] = mk(8'h84, 1, 8'hA5, 8'h00, 1'b1);
        vecs[1] = mk(8'h86, 1, 8'hFF, 8'h00, 1'b0);
        vecs[2] = mk(8'h85, 1, 8'h3C, 8'h00, 1'b1);
        vecs[3] = mk(8'h85, 2, 8'h81, 8'h7E, 1'b1);
        vecs[4] = mk(8'h84, 2, 8'h00, 8'hFF, 1'b1);
        vecs[5] = mk(8'h87, 1, 8'h55, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nack_rx", 32'(nack_rx), 32'd0);
        reset_n = 1'b1;
        q();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Repeated START after a partial write byte, then a read.
        rx0 = n_rx;
        tq0 = n_txreq;
        start_c();
        write_byte(8'h84, ack);
        chk("rs_wr_ack", 32'(ack), 32'd1);
        a = 8'hA0;
        for (int i = 7; i >= 4; i--) bit_out(a[i]);
        tx_data = 8'hC3;
        exp_rd.push_back(8'hC3);
        start_c();
        write_byte(8'h85, ack);
        chk("rs_rd_ack", 32'(ack), 32'd1);
        chk("rs_busy", 32'(busy), 32'd1);
        read_data(b);
        chk("rs_rd_byte", 32'(b), 32'(exp_rd.pop_front()));
        ack_out(1'b0);
        stop_c();
        chk("rs_no_rx", 32'(n_rx - rx0), 32'd0);
        chk("rs_txreq", 32'(n_txreq - tq0), 32'd1);

        // Reset while the slave drives the address ACK.
        start_c();
        a = 8'h84;
        for (int i = 7; i >= 0; i--) bit_out(a[i]);
        m_sda = 1'b1;
        q();
        chk("ack_drive", 32'(sda_oe), 32'd1);
        chk("ack_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("oe_async_rst", 32'(sda_oe), 32'd0);
        chk("busy_async_rst", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rx0 = n_rx;
        n_oe = 0;
        scl = 1'b1; q();
        q();
        scl = 1'b0; q();
        write_byte(8'hA5, ack);
        chk("post_rst_ack", 32'(ack), 32'd0);
        stop_c();
        chk("post_rst_oe", 32'(n_oe), 32'd0);
        chk("post_rst_rx", 32'(n_rx - rx0), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
